reg_op_unit: RTL

- Parametrised successor to the fixed 8x16 op-code register block: a register file of DEPTH x DATA_W entries, driven by op_code/address/data requests.
- Requests and responses use valid/ready handshakes. Every op returns a response carrying the resulting register value. Illegal ops and out-of-range addresses return an error response.
- Sits behind the design interface as the DUT core for the playground UVM bench.

---
 rtl/reg_op_pkg.sv | 28 ++
 rtl/reg_op_alu.sv | 41 ++++
 rtl/reg_op_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/reg_op_pkg.sv
// Shared types for the op-code register unit: op codes, FSM states and write decode.
package reg_op_pkg;

  localparam int unsigned OP_W = 8;

  typedef enum logic [OP_W-1:0] {
    OP_WRITE = 8'd1,
    OP_SHR   = 8'd2,
    OP_SHL   = 8'd3,
    OP_INV   = 8'd4,
    OP_READ  = 8'd5,
    OP_ADD   = 8'd6
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  function automatic logic writes_reg(op_e op);
    case (op)
      OP_WRITE, OP_SHR, OP_SHL, OP_INV, OP_ADD: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_op_alu.sv
// Combinational result/write-enable decode for one register op.
// Define REG_OP_SAT_EN to make ADD saturate instead of wrapping.
module reg_op_alu
  import reg_op_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] cur_val,
  output logic [DATA_W-1:0] result,
  output logic              wr_en,
  output logic              illegal
);

`ifdef REG_OP_SAT_EN
  logic [DATA_W:0] sum;
  assign sum = {1'b0, cur_val} + {1'b0, operand};
`endif

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_WRITE: result = operand;
      OP_SHR:   result = operand >> 1;
      OP_SHL:   result = operand << 1;
      OP_INV:   result = ~operand;
      OP_READ:  result = cur_val;
`ifdef REG_OP_SAT_EN
      OP_ADD:   result = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
      OP_ADD:   result = cur_val + operand;
`endif
      default:  illegal = 1'b1;
    endcase
  end

  assign wr_en = !illegal && writes_reg(op_e'(op));

endmodule

// File: rtl/reg_op_unit.sv
// DEPTH x DATA_W register file driven by valid/ready op requests, one in flight at a time.
// Build with REG_OP_SAT_EN defined for saturating ADD (see reg_op_alu).
module reg_op_unit
  import reg_op_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   op_code,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  // Wide enough to compare any address against any register index without aliasing.
  localparam int unsigned CMP_W = (ADDR_W > 32) ? ADDR_W : 32;

  state_e state_q, state_d;
  logic   req_ready_q;

  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic [DATA_W-1:0] regs_q [DEPTH];

  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic              addr_ok;
  logic [DEPTH-1:0]  addr_sel;
  logic [DEPTH-1:0]  wr_sel;
  logic [DATA_W-1:0] cur_val;
  logic [DATA_W-1:0] alu_result;
  logic              alu_we;
  logic              alu_illegal;

  assign accept = (state_q == IDLE) && req_ready_q && req_valid;

  // One-hot register select; no bit set means the address is out of range.
  always_comb begin
    addr_sel = '0;
    cur_val  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CMP_W'(addr_q) == CMP_W'(i)) begin
        addr_sel[i] = 1'b1;
        cur_val     = regs_q[i];
      end
    end
  end

  assign addr_ok = |addr_sel;

  reg_op_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op      (op_q),
    .operand (data_q),
    .cur_val (cur_val),
    .result  (alu_result),
    .wr_en   (alu_we),
    .illegal (alu_illegal)
  );

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wr_sel     = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        state_d = RESP;
        // Range error outranks op decode: nothing is written either way.
        if (!addr_ok || alu_illegal) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = alu_result;
          rsp_err_d  = 1'b0;
          if (alu_we) wr_sel = addr_sel;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        op_q   <= op_code;
        addr_q <= address;
        data_q <= data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) regs_q[i] <= alu_result;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
